// File: rtl/board_input_conditioner_if.sv
// board_input_conditioner_if
//   Pin-side bundle for board_input_conditioner.
//   raw_i    : asynchronous, bouncy pin levels (driven by the board/master)
//   stable_o : debounced level per channel
//   rise_o   : one-cycle pulse when stable_o[i] goes 0->1
//   fall_o   : one-cycle pulse when stable_o[i] goes 1->0
//   Modports: master drives raw_i, slave (the conditioner) drives the rest.
interface board_input_conditioner_if #(
    parameter int unsigned NumInputs = 5
) ();
    logic [NumInputs-1:0] raw_i;
    logic [NumInputs-1:0] stable_o;
    logic [NumInputs-1:0] rise_o;
    logic [NumInputs-1:0] fall_o;

    modport master (
        output raw_i,
        input  stable_o,
        input  rise_o,
        input  fall_o
    );

    modport slave (
        input  raw_i,
        output stable_o,
        output rise_o,
        output fall_o
    );
endinterface

// File: rtl/board_input_conditioner.sv
// board_input_conditioner
//   Synchronises, debounces and edge-detects raw board inputs (buttons,
//   switches) ahead of the SoC wrapper's reset, fetch-enable and GPIO inputs.
//   Every channel is independent: a SyncStages-deep synchroniser feeds a
//   per-channel counter; a new level is accepted once it has been seen for
//   DebounceCycles consecutive cycles after synchronisation.
//
//   Ports:
//     clk_i : board clock, single clock domain
//     rst_i : synchronous, active-high reset
//     bus   : board_input_conditioner_if.slave (raw_i in; stable_o, rise_o,
//             fall_o out)
//
//   Optional feature macro: BOARD_INPUT_COND_EDGE_EN
//     defined   -> registered rise_o/fall_o edge pulses
//     undefined -> rise_o/fall_o tied to 0, no edge registers
module board_input_conditioner #(
    parameter int unsigned          NumInputs      = 5,
    parameter int unsigned          SyncStages     = 2,
    parameter int unsigned          DebounceCycles = 1_000_000,
    parameter logic [NumInputs-1:0] ResetLevel     = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    board_input_conditioner_if.slave   bus
);

    localparam int unsigned       CntW    = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0]   CntLast = CntW'(DebounceCycles - 1);

    logic [NumInputs-1:0] sync_q [SyncStages];
    logic [NumInputs-1:0] sync;
    logic [NumInputs-1:0] stable_q;
    logic [CntW-1:0]      cnt_q  [NumInputs];
    logic [NumInputs-1:0] accept;

    // Synchroniser chain; the last stage is the debouncer's view of the pin.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < SyncStages; s++) begin
                sync_q[s] <= ResetLevel;
            end
        end else begin
            sync_q[0] <= bus.raw_i;
            for (int unsigned s = 1; s < SyncStages; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SyncStages-1];

    // A channel accepts its new level on the cycle its mismatch count hits
    // the terminal value; this is the only way the counter returns to 0
    // while still mismatched, so it never wraps.
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < NumInputs; i++) begin
            accept[i] = (sync[i] != stable_q[i]) && (cnt_q[i] == CntLast);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= ResetLevel;
            for (int unsigned i = 0; i < NumInputs; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumInputs; i++) begin
                if (sync[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (accept[i]) begin
                    stable_q[i] <= sync[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign bus.stable_o = stable_q;

`ifdef BOARD_INPUT_COND_EDGE_EN
    logic [NumInputs-1:0] rise_q;
    logic [NumInputs-1:0] fall_q;

    // Pulses are registered alongside the stable_o update so they appear in
    // the first cycle stable_o shows the new level. Reset never pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= accept & sync;
            fall_q <= accept & ~sync;
        end
    end

    assign bus.rise_o = rise_q;
    assign bus.fall_o = fall_q;
`else
    assign bus.rise_o = '0;
    assign bus.fall_o = '0;
`endif

endmodule

// File: doc/board_input_conditioner.md
# board_input_conditioner

Synchronises, debounces and edge-detects raw board-level inputs (push-buttons, slide switches) before they enter the FPGA top level as reset, fetch-enable and GPIO inputs. Sits directly upstream of the SoC wrapper, between the package pins and the SoC's `sys_reset`, `fetch_en_i` and `gpio_i` inputs. It runs on the board clock, so the conditioned reset button can drive the wrapper's reset input.

## Interface
- `NumInputs`, default 5: number of independent channels (3 GPIO, fetch-enable, reset button).
- `SyncStages`, default 2: flip-flop stages per channel synchroniser. Must be ≥ 2.
- `DebounceCycles`, default 1_000_000 (10 ms at 100 MHz): consecutive cycles a new level must persist before it is accepted. Must be ≥ 1.
- `ResetLevel`, default `'0`: `NumInputs`-bit per-channel reset value of the synchroniser and `stable_o`.

Ports:
- `clk_i` input, 1 bit: board clock. Single clock domain.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `raw_i` input, `NumInputs` bits: asynchronous, bouncy pin levels.
- `stable_o` output, `NumInputs` bits: debounced level per channel.
- `rise_o` output, `NumInputs` bits: one-cycle pulse when `stable_o[i]` goes 0→1.
- `fall_o` output, `NumInputs` bits: one-cycle pulse when `stable_o[i]` goes 1→0.

## Operation
- Each channel is fully independent. There is no cross-channel interaction.
- **Synchroniser:** `SyncStages`-deep flip-flop chain. The last stage is `sync[i]`.
- **Counter:** width `$clog2(DebounceCycles+1)`.
- **Counter update rule, per channel, each rising edge of `clk_i`:**
  - If `sync[i] == stable_o[i]`, the counter clears to 0.
  - Otherwise, if `counter == DebounceCycles-1`: `stable_o[i]` is set to `sync[i]`, the counter clears, and the matching `rise_o[i]` or `fall_o[i]` is set for the next cycle.
  - Otherwise, the counter increments by 1.
- **Channel states:**
  - IDLE: counter = 0, level matched.
  - PENDING: mismatch, counting.
  - PENDING→IDLE without update on any cycle where the level returns to match (glitch rejected).
  - PENDING→IDLE with update on terminal count.
- The counter never wraps. It saturates only through the terminal-count clear.
- **Edge pulses:** registered, high for exactly one cycle. That cycle is the first cycle in which `stable_o` shows the new value. `rise_o[i]` and `fall_o[i]` are never high together.
- **Reset:** while `rst_i=1`, every edge forces:
  - all synchroniser stages and `stable_o` to `ResetLevel`;
  - counters to 0;
  - `rise_o` and `fall_o` to 0.
- Reset asserted mid-count discards the pending transition. Reset itself never produces an edge pulse, even when `stable_o` changes because of it.
- Reset values: `stable_o = ResetLevel`, `rise_o = 0`, `fall_o = 0`.

## Timing
- Latency from the first edge sampling the new `raw_i` level to `stable_o` changing is `SyncStages + DebounceCycles` edges, provided the level is held throughout. `rise_o`/`fall_o` assert at the same edge.
- Minimum accepted pulse width: `DebounceCycles` cycles after synchronisation. Any shorter excursion produces no output change.
- A level held for `DebounceCycles-1` cycles followed by one cycle of the original level restarts the count from 0.
- Back-to-back transitions are accepted. After an update the channel is immediately in IDLE, and a new mismatch starts counting on the next edge.
- `DebounceCycles = 1`: the update happens on the first mismatching cycle after the synchroniser.

## Configuration
- Macro: `BOARD_INPUT_COND_EDGE_EN`.
- **Defined:** `rise_o`/`fall_o` edge registers are implemented as specified above.
- **Undefined:** `rise_o` and `fall_o` are tied to constant 0 and no edge registers are instantiated. `stable_o` behaviour is unchanged.

## Test plan
Bench parameters: `SyncStages=2`, `DebounceCycles=4`, `NumInputs=5`, `ResetLevel=5'b00000`, macro defined.
- **Reset values:** hold `rst_i=1` for 3 cycles with `raw_i=5'b11111` → `stable_o=0`, `rise_o=0`, `fall_o=0` throughout. Release reset and hold `raw_i` → `stable_o=5'b11111` exactly 6 edges later, with `rise_o=5'b11111` for that one cycle.
- **Clean rise:** set `raw_i[0]` 0→1 and hold → `stable_o[0]=1` and `rise_o[0]=1` at edge 6. `rise_o[0]=0` at edge 7. Other bits unchanged.
- **Glitch rejection:** pulse `raw_i[1]` high for 3 cycles, then low → `stable_o[1]` stays 0 and no pulse occurs. Pulse it high for 4 cycles → `stable_o[1]` rises, then falls 6 edges after `raw_i` drops, with one `fall_o[1]` pulse.
- **Restart:** hold `raw_i[2]` high 3 cycles, low 1 cycle, high 4 cycles → exactly one `rise_o[2]`, 6 edges after the final rising of `raw_i`.
- **Reset mid-count:** raise `raw_i[3]` and assert `rst_i` for 1 cycle at count 2 → no pulse. After release, `stable_o[3]` rises 6 edges later.
- **Macro undefined:** rerun the clean-rise scenario → `stable_o` timing is identical and `rise_o`/`fall_o` stay 0.
